audio_sample_fifo: RTL and testbench

//  Memory-mapped audio stage on the picosoc iomem bus, upstream of pdm_dac. Software pushes 12-bit samples

---
 rtl/audio_fifo_pkg.sv | 24 ++
 rtl/audio_sample_fifo_if.sv | 24 ++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/audio_sample_fifo.sv | 122 ++++++++++++
 tb/tb_audio_sample_fifo.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_fifo_pkg.sv
// Shared constants for the audio sample FIFO: register map, bit positions and
// the midscale value that sample_out takes after reset.
package audio_fifo_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] REG_DATA = 8'h00;
   localparam logic [ADDR_W-1:0] REG_STAT = 8'h04;
   localparam logic [ADDR_W-1:0] REG_DIV  = 8'h08;
   localparam logic [ADDR_W-1:0] REG_CTRL = 8'h0C;

   localparam int unsigned STAT_EMPTY    = 8;
   localparam int unsigned STAT_FULL     = 9;
   localparam int unsigned STAT_UNDERRUN = 10;
   localparam int unsigned STAT_OVERFLOW = 11;

   localparam int unsigned CTRL_EN        = 0;
   localparam int unsigned CTRL_FLUSH     = 1;
   localparam int unsigned CTRL_LOWAT_LSB = 8;

   localparam logic [11:0] MIDSCALE = 12'h800;

endpackage

// File: rtl/audio_sample_fifo_if.sv
// picosoc iomem slave port as seen by the audio sample FIFO; sel is the
// top-level address-window decode.
interface audio_sample_fifo_if;
   import audio_fifo_pkg::*;

   logic              sel;
   logic              iomem_valid;
   logic              iomem_ready;
   logic [3:0]        iomem_wstrb;
   logic [ADDR_W-1:0] iomem_addr;
   logic [DATA_W-1:0] iomem_wdata;
   logic [DATA_W-1:0] iomem_rdata;

   modport master (
      output sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      input  iomem_ready, iomem_rdata
   );

   modport slave (
      input  sel, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
      output iomem_ready, iomem_rdata
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; a push while full is only taken when a pop
// frees the head slot in the same cycle.
module sync_fifo #(
   parameter int unsigned W          = 12,
   parameter int unsigned DEPTH_LOG2 = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   input  logic [W-1:0]        din,
   output logic [W-1:0]        head,
   output logic [DEPTH_LOG2:0] level,
   output logic                empty,
   output logic                full
);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

   logic [W-1:0]          mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic                  do_pop_c;
   logic                  do_push_c;
   logic [LVL_W-1:0]      level_nxt_c;

   assign head = mem[rd_ptr];

   // Flush overrides both ports; level is unchanged when push and pop coincide.
   always_comb begin
      do_pop_c    = pop & ~empty & ~flush;
      do_push_c   = push & ~flush & (~full | do_pop_c);
      level_nxt_c = level;
      if (flush) begin
         level_nxt_c = '0;
      end else if (do_push_c & ~do_pop_c) begin
         level_nxt_c = level + LVL_W'(1);
      end else if (do_pop_c & ~do_push_c) begin
         level_nxt_c = level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         empty  <= 1'b1;
         full   <= 1'b0;
      end else begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (do_pop_c)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (do_push_c) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         end
         level <= level_nxt_c;
         empty <= (level_nxt_c == '0);
         full  <= (level_nxt_c == LVL_W'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/audio_sample_fifo.sv
// Memory-mapped audio sample buffer: CPU pushes samples over iomem, a
// programmable timer presents one sample per period to the PDM DAC.
module audio_sample_fifo
   import audio_fifo_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 6,
   parameter int unsigned SAMPLE_W   = 12,
   parameter logic [15:0] DIV_RESET  = 16'd1999
) (
   input  logic                clk,
   input  logic                reset,
   audio_sample_fifo_if.slave  bus,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                irq
);
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
   localparam int unsigned CMP_W = (LVL_W > 8) ? LVL_W : 8;

   logic [SAMPLE_W-1:0] head;
   logic [LVL_W-1:0]    level;
   logic                empty;
   logic                full;
   logic [15:0]         div;
   logic [15:0]         timer;
   logic [15:0]         div_nxt_c;
   logic                enable;
   logic                underrun;
   logic                overflow;
   logic [7:0]          lowat;
   logic                ack_c, wr_c, rd_c, push_c, flush_c, tick_c, pop_ok_c;
   logic                div_wr_c, ctrl_wr_c, stat_wr_c, ovf_set_c;
   logic [DATA_W-1:0]   rdata_c;

   sync_fifo #(
      .W          (SAMPLE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .pop   (tick_c),
      .flush (flush_c),
      .din   (bus.iomem_wdata[SAMPLE_W-1:0]),
      .head  (head),
      .level (level),
      .empty (empty),
      .full  (full)
   );

   // Bus decode, timer tick and read-data mux.
   always_comb begin
      ack_c     = bus.sel & bus.iomem_valid & ~bus.iomem_ready;
      wr_c      = ack_c & (|bus.iomem_wstrb);
      rd_c      = ack_c & ~(|bus.iomem_wstrb);
      push_c    = wr_c & (bus.iomem_addr == REG_DATA) & (|bus.iomem_wstrb[1:0]);
      div_wr_c  = wr_c & (bus.iomem_addr == REG_DIV);
      ctrl_wr_c = wr_c & (bus.iomem_addr == REG_CTRL);
      stat_wr_c = wr_c & (bus.iomem_addr == REG_STAT) & bus.iomem_wstrb[1];
      flush_c   = ctrl_wr_c & bus.iomem_wstrb[0] & bus.iomem_wdata[CTRL_FLUSH];
      tick_c    = enable & (timer == '0);
      pop_ok_c  = tick_c & ~empty & ~flush_c;
      ovf_set_c = push_c & full & ~pop_ok_c;

      div_nxt_c = div;
      if (bus.iomem_wstrb[0]) div_nxt_c[7:0]  = bus.iomem_wdata[7:0];
      if (bus.iomem_wstrb[1]) div_nxt_c[15:8] = bus.iomem_wdata[15:8];

      rdata_c = '0;
      case (bus.iomem_addr)
         REG_STAT: begin
            rdata_c[7:0]          = 8'(level);
            rdata_c[STAT_EMPTY]    = empty;
            rdata_c[STAT_FULL]     = full;
            rdata_c[STAT_UNDERRUN] = underrun;
            rdata_c[STAT_OVERFLOW] = overflow;
         end
         REG_DIV:  rdata_c[15:0] = div;
         REG_CTRL: begin
            rdata_c[CTRL_EN]             = enable;
            rdata_c[CTRL_LOWAT_LSB +: 8] = lowat;
         end
         default:  rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.iomem_ready <= 1'b0;
         bus.iomem_rdata <= '0;
         sample_out      <= SAMPLE_W'(MIDSCALE);
         irq             <= 1'b0;
         div             <= DIV_RESET;
         timer           <= DIV_RESET;
         enable          <= 1'b0;
         lowat           <= '0;
         underrun        <= 1'b0;
         overflow        <= 1'b0;
      end else begin
         bus.iomem_ready <= ack_c;
         bus.iomem_rdata <= rd_c ? rdata_c : '0;

         if (div_wr_c) div <= div_nxt_c;

         // A DIV write restarts the period immediately.
         if (div_wr_c)              timer <= div_nxt_c;
         else if (!enable || tick_c) timer <= div;
         else                        timer <= timer - 16'd1;

         if (ctrl_wr_c && bus.iomem_wstrb[0]) enable <= bus.iomem_wdata[CTRL_EN];
         if (ctrl_wr_c && bus.iomem_wstrb[1]) lowat  <= bus.iomem_wdata[CTRL_LOWAT_LSB +: 8];

         if (pop_ok_c) sample_out <= head;

         // Sticky flags: a new event in the clearing cycle wins.
         underrun <= (underrun & ~(stat_wr_c & bus.iomem_wdata[STAT_UNDERRUN])) | (tick_c & empty);
         overflow <= (overflow & ~(stat_wr_c & bus.iomem_wdata[STAT_OVERFLOW])) | ovf_set_c;

         irq <= enable & (CMP_W'(level) <= CMP_W'(lowat));
      end
   end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: queue-based reference model, scoreboard of bus
// responses, directed scenarios followed by randomized register traffic.
module tb_audio_sample_fifo;

   localparam int DEPTH = 64;

   typedef struct {
      bit          is_rd;
      logic [31:0] data;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] sample_out;
   logic        irq;

   int checks = 0;
   int errors = 0;

   audio_sample_fifo_if bus ();

   audio_sample_fifo #(
      .DEPTH_LOG2 (6),
      .SAMPLE_W   (12),
      .DIV_RESET  (16'd1999)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .sample_out (sample_out),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [11:0] m_q[$];
   logic [11:0] m_sample = 12'h800;
   logic        m_irq    = 1'b0;
   logic        m_ready  = 1'b0;
   logic        m_en     = 1'b0;
   logic [7:0]  m_lowat  = 8'd0;
   logic [15:0] m_div    = 16'd1999;
   int          m_timer  = 1999;
   logic        m_under  = 1'b0;
   logic        m_over   = 1'b0;
   exp_t        exp_q[$];

   always @(posedge clk) begin : model
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] rv;
      logic [3:0]  s;
      bit          ack, wr, rd, push, flush, tick, n_irq;
      if (reset) begin
         m_q.delete();
         m_sample = 12'h800;
         m_irq    = 1'b0;
         m_ready  = 1'b0;
         m_en     = 1'b0;
         m_lowat  = 8'd0;
         m_div    = 16'd1999;
         m_timer  = 1999;
         m_under  = 1'b0;
         m_over   = 1'b0;
      end else begin
         a   = bus.iomem_addr;
         d   = bus.iomem_wdata;
         s   = bus.iomem_wstrb;
         ack = bus.sel && bus.iomem_valid && !m_ready;
         wr  = ack && (s != 4'h0);
         rd  = ack && (s == 4'h0);
         tick = m_en && (m_timer == 0);
         if (rd) begin
            rv = 32'h0;
            case (a)
               8'h04: begin
                  rv[7:0] = 8'(m_q.size());
                  rv[8]   = (m_q.size() == 0);
                  rv[9]   = (m_q.size() == DEPTH);
                  rv[10]  = m_under;
                  rv[11]  = m_over;
               end
               8'h08: rv[15:0] = m_div;
               8'h0C: begin
                  rv[0]    = m_en;
                  rv[15:8] = m_lowat;
               end
               default: rv = 32'h0;
            endcase
            exp_q.push_back('{is_rd: 1'b1, data: rv});
         end else if (wr) begin
            exp_q.push_back('{is_rd: 1'b0, data: 32'h0});
         end
         push  = wr && (a == 8'h00) && (s[1:0] != 2'b00);
         flush = wr && (a == 8'h0C) && s[0] && d[1];
         n_irq = m_en && (m_q.size() <= int'(m_lowat));
         if (wr && a == 8'h04 && s[1]) begin
            if (d[10]) m_under = 1'b0;
            if (d[11]) m_over  = 1'b0;
         end
         if (tick && m_q.size() == 0) m_under = 1'b1;
         if (flush) begin
            m_q.delete();
         end else begin
            if (tick && m_q.size() > 0) m_sample = m_q.pop_front();
            if (push) begin
               if (m_q.size() < DEPTH) m_q.push_back(d[11:0]);
               else                    m_over = 1'b1;
            end
         end
         if (wr && a == 8'h08) begin
            if (s[0]) m_div[7:0]  = d[7:0];
            if (s[1]) m_div[15:8] = d[15:8];
            m_timer = int'(m_div);
         end else if (!m_en || tick) begin
            m_timer = int'(m_div);
         end else begin
            m_timer = m_timer - 1;
         end
         if (wr && a == 8'h0C) begin
            if (s[0]) m_en    = d[0];
            if (s[1]) m_lowat = d[15:8];
         end
         m_irq   = n_irq;
         m_ready = ack;
      end
   end

   // Monitor: outputs every cycle, bus responses against the scoreboard queue.
   always @(negedge clk) begin : monitor
      exp_t e;
      checks++;
      if (sample_out !== m_sample) begin
         errors++;
         $display("FAIL sample_out got %03h exp %03h t=%0t", sample_out, m_sample, $time);
      end
      checks++;
      if (irq !== m_irq) begin
         errors++;
         $display("FAIL irq got %b exp %b t=%0t", irq, m_irq, $time);
      end
      checks++;
      if (bus.iomem_ready !== m_ready) begin
         errors++;
         $display("FAIL ready got %b exp %b t=%0t", bus.iomem_ready, m_ready, $time);
      end
      if (bus.iomem_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack got ready=1 exp no ack t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            if (e.is_rd) begin
               checks++;
               if (bus.iomem_rdata !== e.data) begin
                  errors++;
                  $display("FAIL rdata got %08h exp %08h t=%0t", bus.iomem_rdata, e.data, $time);
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic xfer(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rdv);
      int n = 0;
      bus.sel         = 1'b1;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = a;
      bus.iomem_wdata = d;
      bus.iomem_wstrb = s;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.iomem_ready !== 1'b1 && n < 8);
      checks++;
      if (bus.iomem_ready !== 1'b1) begin
         errors++;
         $display("FAIL bus_ack got no ready exp ready within 8 cycles addr=%02h", a);
      end
      rdv             = bus.iomem_rdata;
      bus.iomem_valid = 1'b0;
      bus.sel         = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      xfer(a, d, s, dummy);
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] v);
      xfer(a, 32'h0, 4'h0, v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h exp %08h", name, got, exp);
      end
   endtask

   initial begin : stim
      logic [31:0] v;
      logic [11:0] held;
      bus.sel         = 1'b0;
      bus.iomem_valid = 1'b0;
      bus.iomem_wstrb = 4'h0;
      bus.iomem_addr  = 8'h00;
      bus.iomem_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      rd(8'h04, v); chk("reset_stat", v, 32'h100);
      rd(8'h08, v); chk("reset_div", v, 32'd1999);
      chk("reset_sample", 32'(sample_out), 32'h800);
      chk("reset_irq", 32'(irq), 32'h0);

      // Paced playback then underrun
      wr(8'h08, 32'd3, 4'h3);
      wr(8'h00, 32'h111, 4'hF);
      wr(8'h00, 32'h222, 4'hF);
      wr(8'h00, 32'h333, 4'hF);
      wr(8'h0C, 32'h1, 4'h1);
      idle(20);
      chk("play_last", 32'(sample_out), 32'h333);
      rd(8'h04, v); chk("underrun_stat", v, 32'h500);

      // Overflow while disabled
      wr(8'h0C, 32'h0, 4'h3);
      wr(8'h04, 32'hC00, 4'h2);
      for (int i = 0; i < 65; i++) wr(8'h00, 32'h100 + 32'(i), 4'h3);
      rd(8'h04, v); chk("overflow_stat", v, 32'hA40);

      // Push on a pop tick while full is accepted
      wr(8'h04, 32'h800, 4'h2);
      wr(8'h08, 32'd2, 4'h3);
      wr(8'h0C, 32'h1, 4'h1);
      idle(2);
      wr(8'h00, 32'h5A5, 4'hF);
      rd(8'h04, v); chk("full_tick_push", v, 32'h240);
      wr(8'h0C, 32'h0, 4'h1);

      // Low-water irq
      wr(8'h0C, 32'h2, 4'h1);
      wr(8'h04, 32'hC00, 4'h2);
      for (int i = 0; i < 4; i++) wr(8'h00, 32'h700 + 32'(i), 4'hF);
      wr(8'h08, 32'd3, 4'h3);
      wr(8'h0C, 32'h0201, 4'h3);
      idle(14);
      wr(8'h00, 32'h777, 4'hF);
      idle(30);
      wr(8'h0C, 32'h0, 4'h3);

      // Flush keeps sample_out
      for (int i = 0; i < 3; i++) wr(8'h00, 32'h0A0 + 32'(i), 4'hF);
      held = m_sample;
      wr(8'h0C, 32'h2, 4'h1);
      chk("flush_sample", 32'(sample_out), 32'(held));
      wr(8'h04, 32'hC00, 4'h2);
      rd(8'h04, v); chk("flush_stat", v, 32'h100);

      // Reset in the middle of a burst with a request pending
      wr(8'h08, 32'd1, 4'h3);
      for (int i = 0; i < 5; i++) wr(8'h00, 32'h3C0 + 32'(i), 4'hF);
      wr(8'h0C, 32'h0301, 4'h3);
      idle(3);
      bus.sel         = 1'b1;
      bus.iomem_valid = 1'b1;
      bus.iomem_addr  = 8'h00;
      bus.iomem_wdata = 32'h123;
      bus.iomem_wstrb = 4'hF;
      reset           = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus.iomem_ready), 32'h0);
      chk("rst_sample", 32'(sample_out), 32'h800);
      chk("rst_irq", 32'(irq), 32'h0);
      bus.sel         = 1'b0;
      bus.iomem_valid = 1'b0;
      reset           = 1'b0;
      rd(8'h08, v); chk("rst_div", v, 32'd1999);
      rd(8'h04, v); chk("rst_stat", v, 32'h100);
      rd(8'h0C, v); chk("rst_ctrl", v, 32'h0);

      // Randomized register traffic
      wr(8'h08, 32'd2, 4'h3);
      for (int n = 0; n < 500; n++) begin
         int unsigned op;
         op = $urandom_range(0, 11);
         if (op <= 4) begin
            logic [3:0] st;
            case ($urandom_range(0, 3))
               0: st = 4'hF;
               1: st = 4'h1;
               2: st = 4'h2;
               default: st = 4'h4;
            endcase
            wr(8'h00, $urandom, st);
         end else if (op == 5) begin
            logic [7:0] ra;
            case ($urandom_range(0, 4))
               0: ra = 8'h00;
               1: ra = 8'h04;
               2: ra = 8'h08;
               3: ra = 8'h0C;
               default: ra = 8'h10;
            endcase
            rd(ra, v);
         end else if (op == 6) begin
            wr(8'h08, 32'($urandom_range(0, 5)), ($urandom_range(0, 1) != 0) ? 4'h1 : 4'h3);
         end else if (op == 7) begin
            logic [31:0] cd;
            cd = (32'($urandom_range(0, 6)) << 8) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) cd = cd | 32'h2;
            wr(8'h0C, cd, 4'h3);
         end else if (op == 8) begin
            wr(8'h04, $urandom & 32'hC00, ($urandom_range(0, 1) != 0) ? 4'h2 : 4'h1);
         end else if (op == 9) begin
            wr(8'h10, $urandom, 4'hF);
         end else if (op == 10) begin
            bus.sel         = 1'b0;
            bus.iomem_valid = 1'b1;
            bus.iomem_addr  = 8'h00;
            bus.iomem_wdata = $urandom;
            bus.iomem_wstrb = 4'hF;
            idle(1);
            bus.iomem_valid = 1'b0;
         end else begin
            idle(int'($urandom_range(0, 3)));
         end
      end

      idle(5);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_resp got %0d outstanding exp 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
